// File: rtl/player_motion_if.sv
// ============================================================================
// player_motion_if : command/feedback bundle between a player controller
//                    (human key decoder or AI) and player_motion_ctrl.
// Revision 1.0
// ============================================================================
`default_nettype none

interface player_motion_if;
  logic              frame_tick;
  logic              move_left;
  logic              move_right;
  logic              jump;
  logic              smash;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic signed [7:0] vel_y;
  logic              airborne;
  logic              smash_active;

  modport master (
    output frame_tick, move_left, move_right, jump, smash,
    input  pos_x, pos_y, vel_y, airborne, smash_active
  );

  modport slave (
    input  frame_tick, move_left, move_right, jump, smash,
    output pos_x, pos_y, vel_y, airborne, smash_active
  );
endinterface

`default_nettype wire

// File: rtl/player_motion_ctrl.sv
// ============================================================================
// player_motion_ctrl : per-frame player position integrator with jump physics,
//                      landing lockout and smash/cooldown timing.
// Revision 1.0
// ============================================================================
`default_nettype none

module player_motion_ctrl #(
  parameter logic [9:0]        START_X        = 10'd210,
  parameter logic [9:0]        X_MIN          = 10'd170,
  parameter logic [9:0]        X_MAX          = 10'd310,
  parameter logic [9:0]        GROUND_Y       = 10'd200,
  parameter logic [9:0]        Y_MIN          = 10'd40,
  parameter logic [9:0]        MOVE_STEP      = 10'd3,
  parameter logic signed [7:0] JUMP_V0        = 8'sd12,
  parameter logic signed [7:0] GRAVITY        = 8'sd1,
  parameter int unsigned       LAND_FRAMES    = 2,
  parameter int unsigned       SMASH_FRAMES   = 8,
  parameter int unsigned       SMASH_COOLDOWN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  player_motion_if.slave   pm
);

  localparam logic [7:0] LAND_N  = 8'(LAND_FRAMES);
  localparam logic [7:0] SMASH_N = 8'(SMASH_FRAMES);
  localparam logic [7:0] COOL_N  = 8'(SMASH_COOLDOWN);

  typedef enum logic [1:0] {V_GROUND = 2'd0, V_AIR = 2'd1, V_LAND = 2'd2} vstate_t;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_COOL = 2'd2} sstate_t;

  vstate_t           vstate_q;
  sstate_t           sstate_q;
  logic [9:0]        pos_x_q, pos_x_d;
  logic [9:0]        pos_y_q;
  logic signed [7:0] vel_y_q;
  logic              airborne_q;
  logic              smash_active_q;
  logic [7:0]        land_cnt_q;
  logic [7:0]        smash_cnt_q;

  logic [10:0]        x_dec, x_inc;
  logic signed [11:0] ny;
  logic signed [8:0]  v_dec;
  logic signed [7:0]  v_next;

  // ---------------- horizontal ----------------
  assign x_dec = {1'b0, pos_x_q} - {1'b0, MOVE_STEP};
  assign x_inc = {1'b0, pos_x_q} + {1'b0, MOVE_STEP};

  always_comb begin
    pos_x_d = pos_x_q;
    if (pm.move_left && !pm.move_right) begin
      // bit 10 set means the subtraction went below zero
      pos_x_d = (x_dec[10] || (x_dec < {1'b0, X_MIN})) ? X_MIN : x_dec[9:0];
    end else if (pm.move_right && !pm.move_left) begin
      pos_x_d = (x_inc > {1'b0, X_MAX}) ? X_MAX : x_inc[9:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             pos_x_q <= START_X;
    else if (pm.frame_tick) pos_x_q <= pos_x_d;
  end

  // ---------------- vertical FSM ----------------
  assign ny     = $signed({2'b00, pos_y_q}) - $signed({{4{vel_y_q[7]}}, vel_y_q});
  assign v_dec  = $signed({vel_y_q[7], vel_y_q}) - $signed({GRAVITY[7], GRAVITY});
  assign v_next = (v_dec < -9'sd128) ? -8'sd128 : v_dec[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vstate_q   <= V_GROUND;
      pos_y_q    <= GROUND_Y;
      vel_y_q    <= 8'sd0;
      airborne_q <= 1'b0;
      land_cnt_q <= 8'd0;
    end else if (pm.frame_tick) begin
      case (vstate_q)
        V_GROUND: begin
          if (pm.jump) begin
            pos_y_q    <= GROUND_Y - {2'b00, JUMP_V0};
            vel_y_q    <= JUMP_V0 - GRAVITY;
            airborne_q <= 1'b1;
            vstate_q   <= V_AIR;
          end
        end
        V_AIR: begin
          if (ny >= $signed({2'b00, GROUND_Y})) begin
            pos_y_q    <= GROUND_Y;
            vel_y_q    <= 8'sd0;
            airborne_q <= 1'b0;
            land_cnt_q <= LAND_N;
            vstate_q   <= (LAND_N == 8'd0) ? V_GROUND : V_LAND;
          end else if ((ny <= $signed({2'b00, Y_MIN})) && (vel_y_q > 8'sd0)) begin
            // Only an upward hit clamps; at rest on the ceiling gravity takes over.
            pos_y_q <= Y_MIN;
            vel_y_q <= 8'sd0;
          end else begin
            pos_y_q <= ny[9:0];
            vel_y_q <= v_next;
          end
        end
        V_LAND: begin
          if (land_cnt_q <= 8'd1) begin
            land_cnt_q <= 8'd0;
            vstate_q   <= V_GROUND;
          end else begin
            land_cnt_q <= land_cnt_q - 8'd1;
          end
        end
        default: vstate_q <= V_GROUND;
      endcase
    end
  end

  // ---------------- smash FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sstate_q       <= S_IDLE;
      smash_active_q <= 1'b0;
      smash_cnt_q    <= 8'd0;
    end else if (pm.frame_tick) begin
      case (sstate_q)
        S_IDLE: begin
          if (pm.smash) begin
            smash_active_q <= 1'b1;
            smash_cnt_q    <= SMASH_N - 8'd1;
            sstate_q       <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (smash_cnt_q == 8'd0) begin
            smash_active_q <= 1'b0;
            smash_cnt_q    <= (COOL_N == 8'd0) ? 8'd0 : COOL_N - 8'd1;
            sstate_q       <= (COOL_N == 8'd0) ? S_IDLE : S_COOL;
          end else begin
            smash_cnt_q <= smash_cnt_q - 8'd1;
          end
        end
        S_COOL: begin
          // Last cooldown tick doubles as the idle check so a held button re-fires at once.
          if (smash_cnt_q == 8'd0) begin
            if (pm.smash) begin
              smash_active_q <= 1'b1;
              smash_cnt_q    <= SMASH_N - 8'd1;
              sstate_q       <= S_ACTIVE;
            end else begin
              sstate_q <= S_IDLE;
            end
          end else begin
            smash_cnt_q <= smash_cnt_q - 8'd1;
          end
        end
        default: sstate_q <= S_IDLE;
      endcase
    end
  end

  assign pm.pos_x        = pos_x_q;
  assign pm.pos_y        = pos_y_q;
  assign pm.vel_y        = vel_y_q;
  assign pm.airborne     = airborne_q;
  assign pm.smash_active = smash_active_q;

endmodule

`default_nettype wire

// File: tb/tb_player_motion_ctrl.sv
// ============================================================================
// tb_player_motion_ctrl : directed stimulus with a queue scoreboard per DUT.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_player_motion_ctrl;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] vy;
    logic       air;
    logic       sm;
  } exp_t;

  logic clk;
  logic rst_n;

  player_motion_if ifa ();
  player_motion_if ifb ();

  player_motion_ctrl u_a (.clk(clk), .rst_n(rst_n), .pm(ifa));
  player_motion_ctrl #(.JUMP_V0(8'sd100)) u_b (.clk(clk), .rst_n(rst_n), .pm(ifb));

  exp_t qa[$];
  exp_t qb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // hand-computed jump trajectory for JUMP_V0=12, GRAVITY=1
  int ytab [25] = '{188, 177, 167, 158, 150, 143, 137, 132, 128, 125, 123, 122, 122,
                    123, 125, 128, 132, 137, 143, 150, 158, 167, 177, 188, 200};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input int x, input int y, input int vy,
                              input bit air, input bit sm);
    exp_t e;
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.vy  = 8'(vy);
    e.air = air;
    e.sm  = sm;
    return e;
  endfunction

  function automatic exp_t snap(input bit sel);
    exp_t e;
    if (sel) e = '{x: ifb.pos_x, y: ifb.pos_y, vy: ifb.vel_y, air: ifb.airborne, sm: ifb.smash_active};
    else     e = '{x: ifa.pos_x, y: ifa.pos_y, vy: ifa.vel_y, air: ifa.airborne, sm: ifa.smash_active};
    return e;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got x=%0d y=%0d vy=%0d air=%0b sm=%0b, want x=%0d y=%0d vy=%0d air=%0b sm=%0b",
               name, $time, act.x, act.y, $signed(act.vy), act.air, act.sm,
               exp.x, exp.y, $signed(exp.vy), exp.air, exp.sm);
    end
  endtask

  // Called at a negedge; issues one frame tick followed by one idle cycle.
  task automatic tick(input bit sel, input bit l, input bit r, input bit j, input bit s,
                      input exp_t e);
    if (sel) begin
      ifb.move_left = l; ifb.move_right = r; ifb.jump = j; ifb.smash = s;
      ifb.frame_tick = 1'b1; qb.push_back(e);
    end else begin
      ifa.move_left = l; ifa.move_right = r; ifa.jump = j; ifa.smash = s;
      ifa.frame_tick = 1'b1; qa.push_back(e);
    end
    @(negedge clk);
    ifa.frame_tick = 1'b0;
    ifb.frame_tick = 1'b0;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    if (rst_n && ifa.frame_tick) begin
      #1;
      if (qa.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL mon_a: output with no expectation queued");
      end else check("tick_a", snap(1'b0), qa.pop_front());
    end
  end

  always @(posedge clk) begin
    if (rst_n && ifb.frame_tick) begin
      #1;
      if (qb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL mon_b: output with no expectation queued");
      end else check("tick_b", snap(1'b1), qb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int x;
    bit sm;
    {ifa.frame_tick, ifa.move_left, ifa.move_right, ifa.jump, ifa.smash} = '0;
    {ifb.frame_tick, ifb.move_left, ifb.move_right, ifb.jump, ifb.smash} = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_a", snap(1'b0), mk(210, 200, 0, 0, 0));
    check("reset_b", snap(1'b1), mk(210, 200, 0, 0, 0));
    rst_n = 1'b1;
    @(negedge clk);

    // horizontal: right to clamp, both held, no-tick hold, left to clamp
    x = 210;
    for (int k = 1; k <= 40; k++) begin
      x = (x + 3 > 310) ? 310 : x + 3;
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(x, 200, 0, 0, 0));
    end
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(310, 200, 0, 0, 0));
    ifa.move_left = 1'b1;
    ifa.jump      = 1'b1;
    repeat (4) @(negedge clk);
    check("no_tick_hold", snap(1'b0), mk(310, 200, 0, 0, 0));
    ifa.jump = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      x = (x - 3 < 170) ? 170 : x - 3;
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(x, 200, 0, 0, 0));
    end

    // jump held: arc, landing lockout, re-jump on tick 28
    for (int k = 1; k <= 25; k++)
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(170, ytab[k-1], (k == 25) ? 0 : 12 - k, k != 25, 1'b0));
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(170, 200, 0, 0, 0));
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(170, 200, 0, 0, 0));
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(170, 188, 11, 1, 0));
    for (int k = 2; k <= 25; k++)
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(170, ytab[k-1], (k == 25) ? 0 : 12 - k, k != 25, 1'b0));
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(170, 200, 0, 0, 0));
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(170, 200, 0, 0, 0));

    // smash held 30 ticks, then released for 20
    for (int k = 1; k <= 50; k++) begin
      sm = (k <= 8) || (k >= 25 && k <= 32);
      tick(1'b0, 1'b0, 1'b0, 1'b0, k <= 30, mk(170, 200, 0, 0, sm));
    end

    // jump + smash + move on the same tick, then continue mid-air
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, mk(173, 188, 11, 1, 1));
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(173, 177, 10, 1, 1));
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(173, 167, 9, 1, 1));

    // asynchronous reset mid-jump / mid-smash, away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_a", snap(1'b0), mk(210, 200, 0, 0, 0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(210, 200, 0, 0, 1));
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(210, 200, 0, 0, 1));

    // high jump on DUT B: ceiling clamp then fall
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, mk(210, 100, 99, 1, 0));
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(210, 40, 0, 1, 0));
    for (int n = 3; n <= 20; n++)
      tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(210, 40 + (n - 3) * (n - 2) / 2, 2 - n, 1, 0));
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(210, 200, 0, 0, 0));
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(210, 200, 0, 0, 0));

    repeat (3) @(negedge clk);
    n_tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d/%0d expectations left, want 0/0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
